// File: rtl/result_copy_pkg.sv
// Shared types and defaults for the result-copy burst engine.
package result_copy_pkg;

  localparam int DEF_WORD_W          = 64;
  localparam int DEF_BEAT_W          = 512;
  localparam int DEF_MEM_AW          = 32;
  localparam int DEF_MAX_CHUNK_WORDS = 512;
  localparam int DEF_RD_LAT          = 1;
  localparam int DEF_FIFO_DEPTH      = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_READ,
    ST_WAIT,
    ST_FINISH
  } state_t;

  function automatic logic [31:0] calc_chunk(input logic [31:0] rem,
                                             input logic [31:0] max_words);
    return (rem < max_words) ? rem : max_words;
  endfunction

endpackage

// File: rtl/result_copy_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Head entry is presented on dout whenever valid is high.
module result_copy_fifo #(
  parameter int W     = 512,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign do_pop  = pop && valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/result_copy_burst.sv
// Copies a span of result RAM into AXI-Stream beats, split into write-master chunks.
// Optional macro RESULT_COPY_TLAST_EN adds m_axis_tlast on the final beat of each chunk.
module result_copy_burst
  import result_copy_pkg::*;
#(
  parameter int WORD_W          = DEF_WORD_W,
  parameter int BEAT_W          = DEF_BEAT_W,
  parameter int MEM_AW          = DEF_MEM_AW,
  parameter int MAX_CHUNK_WORDS = DEF_MAX_CHUNK_WORDS,
  parameter int RD_LAT          = DEF_RD_LAT,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kick,
  output logic              busy,
  input  logic [31:0]       offset,
  input  logic [31:0]       words,
  input  logic [63:0]       memory_addr,
  output logic [MEM_AW-1:0] addr,
  input  logic [WORD_W-1:0] q,
  output logic              ctrl_start,
  input  logic              ctrl_done,
  output logic [63:0]       ctrl_addr_offset,
  output logic [63:0]       ctrl_xfer_size_in_bytes,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [BEAT_W-1:0] m_axis_tdata
`ifdef RESULT_COPY_TLAST_EN
  ,
  output logic              m_axis_tlast
`endif
);

  localparam int WPB    = BEAT_W / WORD_W;
  localparam int BPW    = WORD_W / 8;
  localparam int LANE_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
`ifdef RESULT_COPY_TLAST_EN
  localparam int FW = BEAT_W + 1;
`else
  localparam int FW = BEAT_W;
`endif

  state_t              state;
  logic [31:0]         offset_q;
  logic [63:0]         mem_base;
  logic [31:0]         rem;
  logic [31:0]         done_words;
  logic [31:0]         chunk;
  logic [31:0]         chunk_n;
  logic [31:0]         issued;
  logic [31:0]         rcv;
  logic                done_seen;
  logic [LANE_W-1:0]   issue_lane;
  logic [LANE_W-1:0]   pack_lane;
  logic [BEAT_W-1:0]   pack_data;
  logic [BEAT_W-1:0]   push_data;
  logic [RD_LAT:0]     rd_vld;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    beat_pend;
  logic                issue;
  logic                beat_start;
  logic                capture;
  logic                chunk_last;
  logic                push;
  logic                pop;
  logic [FW-1:0]       fifo_din;
  logic [FW-1:0]       fifo_dout;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    chunk_n    = calc_chunk(rem, 32'(MAX_CHUNK_WORDS));
    capture    = rd_vld[RD_LAT];
    chunk_last = (rcv == chunk - 32'd1);
    push       = capture && ((int'(pack_lane) == WPB - 1) || chunk_last);
    push_data  = pack_data;
    push_data[int'(pack_lane)*WORD_W +: WORD_W] = q;
    // Beats already queued plus beats still forming in the pipeline bound the issue rate.
    issue      = (state == ST_READ) && (issued < chunk) &&
                 ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(beat_pend) <= (CNT_W+1)'(FIFO_DEPTH - 2));
    beat_start = issue && (issue_lane == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= ST_IDLE;
      busy                    <= 1'b0;
      ctrl_start              <= 1'b0;
      addr                    <= '0;
      ctrl_addr_offset        <= '0;
      ctrl_xfer_size_in_bytes <= '0;
      offset_q                <= '0;
      mem_base                <= '0;
      rem                     <= '0;
      done_words              <= '0;
      chunk                   <= '0;
      issued                  <= '0;
      rcv                     <= '0;
      done_seen               <= 1'b0;
      issue_lane              <= '0;
      pack_lane               <= '0;
      pack_data               <= '0;
      rd_vld                  <= '0;
      beat_pend               <= '0;
    end else begin
      ctrl_start <= 1'b0;
      rd_vld     <= (RD_LAT+1)'({rd_vld, issue});

      if (issue) begin
        addr       <= MEM_AW'(offset_q) + MEM_AW'(done_words) + MEM_AW'(issued);
        issued     <= issued + 32'd1;
        issue_lane <= (int'(issue_lane) == WPB - 1) ? '0 : issue_lane + LANE_W'(1);
      end

      case ({beat_start, push})
        2'b10:   beat_pend <= beat_pend + CNT_W'(1);
        2'b01:   beat_pend <= beat_pend - CNT_W'(1);
        default: beat_pend <= beat_pend;
      endcase

      if (capture) begin
        rcv <= rcv + 32'd1;
        if (push) begin
          pack_data <= '0;
          pack_lane <= '0;
        end else begin
          pack_data <= push_data;
          pack_lane <= pack_lane + LANE_W'(1);
        end
      end

      // An early completion during READ must survive until WAIT looks at it.
      if ((state == ST_READ || state == ST_WAIT) && ctrl_done && !ctrl_start)
        done_seen <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (kick) begin
            offset_q   <= offset;
            mem_base   <= memory_addr;
            rem        <= words;
            done_words <= '0;
            busy       <= 1'b1;
            state      <= (words == '0) ? ST_FINISH : ST_START;
          end
        end
        ST_START: begin
          chunk                   <= chunk_n;
          ctrl_addr_offset        <= mem_base + 64'(done_words) * 64'(BPW);
          ctrl_xfer_size_in_bytes <= 64'(chunk_n) * 64'(BPW);
          ctrl_start              <= 1'b1;
          done_seen               <= 1'b0;
          issued                  <= '0;
          rcv                     <= '0;
          issue_lane              <= '0;
          pack_lane               <= '0;
          pack_data               <= '0;
          state                   <= ST_READ;
        end
        ST_READ: begin
          if (capture && chunk_last) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_seen) begin
            done_words <= done_words + chunk;
            rem        <= rem - chunk;
            state      <= (rem != chunk) ? ST_START : ST_FINISH;
          end
        end
        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pop = m_axis_tvalid && m_axis_tready;

`ifdef RESULT_COPY_TLAST_EN
  assign fifo_din     = {chunk_last, push_data};
  assign m_axis_tdata = fifo_dout[BEAT_W-1:0];
  assign m_axis_tlast = m_axis_tvalid && fifo_dout[BEAT_W];
`else
  assign fifo_din     = push_data;
  assign m_axis_tdata = fifo_dout;
`endif

  result_copy_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (m_axis_tvalid),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_result_copy_burst.sv
// Randomized self-checking bench for result_copy_burst against a chunk/beat reference model.
module tb_result_copy_burst;

  localparam int WORD_W     = 64;
  localparam int BEAT_W     = 512;
  localparam int MEM_AW     = 32;
  localparam int MAXC       = 512;
  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 32;
  localparam int WPB        = BEAT_W / WORD_W;
  localparam int BPW        = WORD_W / 8;
  localparam int LAT_MAX    = RD_LAT + WPB + 3;
  localparam int BUDGET     = 20000;

  typedef struct {
    logic [BEAT_W-1:0] data;
    bit                last;
  } beat_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] sz;
    int          prev;
  } ctrl_t;

  logic              clk;
  logic              reset;
  logic              kick;
  logic              busy;
  logic [31:0]       offset;
  logic [31:0]       words;
  logic [63:0]       memory_addr;
  logic [MEM_AW-1:0] addr;
  logic [WORD_W-1:0] q;
  logic              ctrl_start;
  logic              ctrl_done;
  logic [63:0]       ctrl_addr_offset;
  logic [63:0]       ctrl_xfer_size_in_bytes;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [BEAT_W-1:0] m_axis_tdata;
`ifdef RESULT_COPY_TLAST_EN
  logic              m_axis_tlast;
`endif

  logic [63:0] ram_mem [0:4095];
  beat_t       exp_beats[$];
  ctrl_t       exp_ctrl[$];

  int checks = 0;
  int failures = 0;
  int rx_beats = 0;
  int starts_seen = 0;
  int done_cnt = 0;
  int hold_cnt = 0;
  int tready_mode = 0;
  int done_mode = 0;
  bit strict_mode = 0;
  int busy_cyc = 0;
  int first_lat = -1;
  bit hold_pend = 0;
  logic [BEAT_W-1:0] held_data;

  result_copy_burst #(
    .WORD_W          (WORD_W),
    .BEAT_W          (BEAT_W),
    .MEM_AW          (MEM_AW),
    .MAX_CHUNK_WORDS (MAXC),
    .RD_LAT          (RD_LAT),
    .FIFO_DEPTH      (FIFO_DEPTH)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .kick                    (kick),
    .busy                    (busy),
    .offset                  (offset),
    .words                   (words),
    .memory_addr             (memory_addr),
    .addr                    (addr),
    .q                       (q),
    .ctrl_start              (ctrl_start),
    .ctrl_done               (ctrl_done),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .m_axis_tvalid           (m_axis_tvalid),
    .m_axis_tready           (m_axis_tready),
    .m_axis_tdata            (m_axis_tdata)
`ifdef RESULT_COPY_TLAST_EN
    ,
    .m_axis_tlast            (m_axis_tlast)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle-latency RAM; the 4K array aliases the 32-bit address space consistently.
  always @(posedge clk) q <= ram_mem[addr[11:0]];

  task automatic check(input string tag, input logic [BEAT_W-1:0] obs, input logic [BEAT_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected chunk commands and beats, derived from word/chunk arithmetic.
  function automatic void build_expect(input int unsigned w, input logic [31:0] off, input logic [63:0] ma);
    int unsigned done = 0;
    int unsigned rem  = w;
    int          prev = 0;
    exp_beats.delete();
    exp_ctrl.delete();
    while (rem > 0) begin
      int unsigned ch;
      ctrl_t       c;
      ch     = (rem < MAXC) ? rem : MAXC;
      c.a    = ma + 64'(done) * 64'(BPW);
      c.sz   = 64'(ch) * 64'(BPW);
      c.prev = prev;
      exp_ctrl.push_back(c);
      for (int unsigned b = 0; b < ch; b += WPB) begin
        beat_t bt;
        bt.data = '0;
        for (int unsigned l = 0; l < WPB && b + l < ch; l++) begin
          logic [31:0] wa;
          wa = off + done + b + l;
          bt.data[l*WORD_W +: WORD_W] = ram_mem[wa[11:0]];
        end
        bt.last = (b + WPB >= ch);
        exp_beats.push_back(bt);
        prev++;
      end
      done += ch;
      rem  -= ch;
    end
  endfunction

  // Write-master model and tready driver, one step after each active edge.
  initial begin
    forever begin
      ctrl_t c;
      @(posedge clk);
      #1;
      if (reset) begin
        done_cnt  = 0;
        ctrl_done = 1'b0;
      end else begin
        ctrl_done = 1'b0;
        if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) ctrl_done = 1'b1;
        end
        if (ctrl_start) begin
          starts_seen++;
          if (exp_ctrl.size() == 0) begin
            check("extra_ctrl_start", 1, 0);
          end else begin
            c = exp_ctrl.pop_front();
            check("ctrl_addr_offset", ctrl_addr_offset, c.a);
            check("ctrl_xfer_size", ctrl_xfer_size_in_bytes, c.sz);
            if (strict_mode) check("beats_before_start", rx_beats, c.prev);
            done_cnt = (done_mode == 0) ? 1 : int'($urandom_range(1, 30));
          end
        end
      end
      case (tready_mode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = 1'($urandom % 2);
        default: begin
          if (hold_cnt > 0) begin
            m_axis_tready = 1'b0;
            hold_cnt--;
          end else begin
            m_axis_tready = 1'($urandom % 2);
          end
        end
      endcase
    end
  end

  // Stream monitor, sampled on the inactive edge.
  initial begin
    forever begin
      beat_t b;
      @(negedge clk);
      if (reset) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("tvalid_hold", m_axis_tvalid, 1);
          check("tdata_hold", m_axis_tdata, held_data);
        end
        hold_pend = m_axis_tvalid && !m_axis_tready;
        held_data = m_axis_tdata;
        if (m_axis_tvalid && m_axis_tready) begin
          rx_beats++;
          if (exp_beats.size() == 0) begin
            check("extra_beat", 1, 0);
          end else begin
            b = exp_beats.pop_front();
            check("beat_data", m_axis_tdata, b.data);
`ifdef RESULT_COPY_TLAST_EN
            check("beat_tlast", m_axis_tlast, b.last);
`endif
          end
        end
      end
    end
  end

  task automatic run_job(input int unsigned w, input logic [31:0] off, input logic [63:0] ma,
                         input int rmode, input int dmode, input bit strict);
    bit finished;
    build_expect(w, off, ma);
    tready_mode = rmode;
    done_mode   = dmode;
    strict_mode = strict;
    if (rmode == 2) hold_cnt = 200;
    rx_beats    = 0;
    starts_seen = 0;
    busy_cyc    = 0;
    first_lat   = -1;
    finished    = 1'b0;
    words       = w;
    offset      = off;
    memory_addr = ma;
    kick        = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk);
      #1;
      kick = 1'b0;
      if (busy) busy_cyc++;
      if (m_axis_tvalid && first_lat < 0) first_lat = c;
      if (!busy && exp_beats.size() == 0) begin
        finished = 1'b1;
        break;
      end
    end
    check("job_finished", finished, 1);
    check("ctrl_starts_left", exp_ctrl.size(), 0);
    repeat (20) @(posedge clk);
    #1;
    tready_mode = 0;
    strict_mode = 1'b0;
  endtask

  initial begin
    bit progressed;
    reset         = 1'b1;
    kick          = 1'b0;
    offset        = '0;
    words         = '0;
    memory_addr   = '0;
    m_axis_tready = 1'b1;
    ctrl_done     = 1'b0;
    for (int i = 0; i < 4096; i++) ram_mem[i] = {$urandom, $urandom};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ctrl_start", ctrl_start, 0);
    check("rst_addr", addr, 0);
    check("rst_ctrl_addr_offset", ctrl_addr_offset, 0);
    check("rst_ctrl_xfer_size", ctrl_xfer_size_in_bytes, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
`ifdef RESULT_COPY_TLAST_EN
    check("rst_tlast", m_axis_tlast, 0);
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single small chunk, also bounds first-beat latency.
    run_job(16, 32'd0, 64'h1000, 0, 1, 1'b1);
    check("first_beat_latency_ok", (first_lat > 0 && first_lat <= LAT_MAX), 1);
    check("one_chunk_starts", starts_seen, 1);
    check("one_chunk_beats", rx_beats, 2);

    // Two chunks with partial final beat; completion pulsed right after ctrl_start.
    run_job(1005, 32'd10, 64'h0000_0012_3456_7000, 0, 0, 1'b1);
    check("two_chunk_starts", starts_seen, 2);
    check("two_chunk_beats", rx_beats, 126);

    // Long backpressure, then random ready.
    run_job(64, $urandom, {$urandom, $urandom}, 2, 1, 1'b0);
    check("backpressure_beats", rx_beats, 8);

    // Zero-length request.
    run_job(0, 32'd5, 64'h2000, 0, 1, 1'b0);
    check("zero_busy_cycles_ok", (busy_cyc >= 1 && busy_cyc <= 2), 1);
    check("zero_ctrl_starts", starts_seen, 0);
    check("zero_beats", rx_beats, 0);

    // RAM address wrap.
    run_job(40, 32'hFFFF_FFF0, 64'hFFFF_FFFF_FFFF_F000, 1, 1, 1'b0);

    // Randomized lengths, offsets, bases and ready patterns.
    for (int j = 0; j < 5; j++) begin
      run_job($urandom_range(1, 1300), $urandom, {$urandom, $urandom}, int'($urandom % 2), 1, 1'b0);
    end

    // Reset in the middle of a long copy.
    build_expect(1000, 32'd100, 64'h8000);
    tready_mode = 0;
    done_mode   = 1;
    rx_beats    = 0;
    words       = 32'd1000;
    offset      = 32'd100;
    memory_addr = 64'h8000;
    kick        = 1'b1;
    progressed  = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      kick = 1'b0;
      if (rx_beats >= 3) begin
        progressed = 1'b1;
        break;
      end
    end
    check("midreset_progress", progressed, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_tvalid", m_axis_tvalid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_ctrl_start", ctrl_start, 0);
    exp_beats.delete();
    exp_ctrl.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_job(8, 32'd300, 64'h9000, 0, 1, 1'b0);
    check("post_reset_beats", rx_beats, 1);
    check("post_reset_starts", starts_seen, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_copy_burst.md
Name: result_copy_burst

Overview:
- Parametrised successor of the wordcount result-copy engine.
- Reads `words` entries from a local result RAM, starting at `offset`, and packs them into BEAT_W-bit AXI-Stream beats.
- Splits the transfer into chunks of at most MAX_CHUNK_WORDS words. Issues one ctrl_start per chunk to the host-memory write master, at a byte address that advances per chunk.
- Handles partial final beats, arbitrary RAM read latency and downstream backpressure without overflow.

Parameters:
- WORD_W, 64: RAM word width; must divide BEAT_W.
- BEAT_W, 512: stream beat width.
- MEM_AW, 32: RAM address width.
- MAX_CHUNK_WORDS, 512: words per ctrl_start; must be a multiple of BEAT_W/WORD_W.
- RD_LAT, 1: RAM read latency, in cycles from addr to q.
- FIFO_DEPTH, 32: output FIFO depth in beats; power of 2, minimum 8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- kick  in  1  start pulse, sampled only in IDLE
- busy  out  1  high from the kick cycle until the last chunk completes
- offset  in  32  first RAM word index
- words  in  32  total word count
- memory_addr  in  64  host base byte address
- addr  out  MEM_AW  RAM read address
- q  in  WORD_W  RAM read data, valid RD_LAT cycles after addr
- ctrl_start  out  1  one-cycle chunk start pulse
- ctrl_done  in  1  chunk-complete pulse from the write master
- ctrl_addr_offset  out  64  chunk byte address
- ctrl_xfer_size_in_bytes  out  64  chunk size in bytes
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tdata  out  BEAT_W  stream data

Behaviour:
- Reset values:
  - busy=0, ctrl_start=0, addr=0, ctrl_addr_offset=0, ctrl_xfer_size_in_bytes=0, m_axis_tvalid=0.
  - FIFO empty; in-flight read pipeline cleared; FSM in IDLE.
  - Reset mid-operation abandons the transfer and drops all pending beats.
- Derived values: WPB = BEAT_W/WORD_W; BPW = WORD_W/8 (bytes per word).
- States:
  - IDLE: busy=0. On kick: latch offset, words and memory_addr; set rem=words, done_words=0; busy=1.
    - If words==0, go to FINISH.
    - Otherwise go to START. kick in any other state is ignored.
  - START:
    - chunk = min(rem, MAX_CHUNK_WORDS).
    - ctrl_addr_offset = memory_addr + done_words*BPW (64-bit arithmetic).
    - ctrl_xfer_size_in_bytes = chunk*BPW.
    - ctrl_start=1 for exactly this cycle; clear the done_seen flag; go to READ.
  - READ: issue one read per cycle (addr = offset + done_words + issued) while both hold:
    - issued < chunk;
    - fifo_count + beats in the read/pack pipeline ≤ FIFO_DEPTH-2, which guarantees no overflow.
  - READ packing and exit:
    - Returning q fills lanes in order; word i of the chunk goes to tdata bits [(i%WPB)*WORD_W +: WORD_W].
    - A beat is pushed when WPB lanes are filled, or when the chunk's last word arrives. Unfilled lanes of a partial beat are zero.
    - Once every word of the chunk has been pushed, go to WAIT.
  - WAIT: wait for done_seen.
    - done_seen latches ctrl_done from the cycle after ctrl_start, so an early ctrl_done that arrives while still in READ is not lost.
    - Then done_words += chunk, rem -= chunk; go to START if rem>0, else to FINISH.
  - FINISH: busy=0 next cycle; go to IDLE.
- Each chunk begins on a fresh beat; beats never span chunks.
- ctrl_done outside READ/WAIT is ignored.
- Stream output:
  - m_axis_tdata/tvalid come from the FIFO head; a pop happens on tvalid&&tready.
  - tdata is held stable while tvalid=1 and tready=0.
  - Simultaneous push and pop are both performed; the count is unchanged.
- Latency: first beat valid ≤ RD_LAT+WPB+3 cycles after kick, given an empty FIFO and tready=1.
- Width rules: words*BPW is computed in 64 bits. RAM address arithmetic is modulo 2^MEM_AW (wrap allowed).

Optional Feature:
- Macro: RESULT_COPY_TLAST_EN.
- Defined: adds output port m_axis_tlast (1 bit), asserted on the final beat of each chunk. It is stored in the FIFO alongside tdata; reset value 0.
- Undefined: the port is absent and the FIFO is BEAT_W wide.

Decomposition:
- Package result_copy_pkg:
  - state enum typedef state_t;
  - function calc_chunk(rem, max), returning the min;
  - localparam default widths.
- Sub-module result_copy_fifo: synchronous, first-word-fall-through, with count output, width BEAT_W(+1), depth FIFO_DEPTH.

Test Plan:
- words=16, offset=0, memory_addr=0x1000 → one ctrl_start with addr 0x1000, size 128; 2 beats; beat0 lane0=RAM[0], lane7=RAM[7].
- words=1005, offset=10 → chunk1 size 4096 at memory_addr, 64 beats; chunk2 size 3944 at memory_addr+4096, 62 beats. Final beat has lanes 0..4=RAM[1010..1014] and lanes 5..7=0.
- words=64, tready held low 200 cycles then toggled 50% → no FIFO overflow; all 8 beats delivered in order with correct data.
- words=0 kick → busy high ≤2 cycles, no ctrl_start, no beats.
- ctrl_done pulsed 1 cycle after ctrl_start, before the chunk is streamed → FSM advances only after the last beat of the chunk is pushed. With RESULT_COPY_TLAST_EN, tlast is set on beat 64 of the chunk.
- reset asserted mid-READ of a 1000-word copy → next cycle tvalid=0, busy=0, ctrl_start=0; a new kick with words=8 produces exactly one correct beat.
